// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multi-cycle RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_signed_rs1(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(op_e op);
    return op[2] & op[1];
  endfunction

  // Iteration counter must hold the value XLEN itself.
  function automatic int unsigned cnt_width(int unsigned xlen);
    return $clog2(xlen + 1);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two-lane conditional two's-complement negate: magnitudes on accept, sign restore at completion.
module muldiv_signfix #(
  parameter int unsigned WA = 32,
  parameter int unsigned WB = 32
) (
  input  logic [WA-1:0] a_i,
  input  logic          neg_a_i,
  input  logic [WB-1:0] b_i,
  input  logic          neg_b_i,
  output logic [WA-1:0] a_c_o,
  output logic [WB-1:0] b_c_o
);

  assign a_c_o = neg_a_i ? (~a_i + WA'(1)) : a_i;
  assign b_c_o = neg_b_i ? (~b_i + WB'(1)) : b_i;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension unit: one result bit per cycle, registered result and tag,
// combinational stall toward the hazard logic.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o
);

  localparam int unsigned CNT_W = cnt_width(XLEN);
  localparam int unsigned AW    = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = XLEN'(1) << (XLEN - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic [XLEN-1:0]    mc_q, mc_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic               done_q, done_d;

  op_e                op_in;
  logic               accept, sgn1_in, sgn2_in, div0, ovf, special;
  logic [XLEN-1:0]    mag1, mag2, spec_val;
  logic [XLEN:0]      mul_sum, rem_sh;
  logic               q_bit;
  logic [XLEN-1:0]    rem_new;
  logic [AW-1:0]      mul_nx, div_nx, acc_nx, fix_a;
  logic [XLEN-1:0]    div_sel, fix_b, calc_res;

  assign op_in   = op_e'(op_i);
  assign accept  = (state_q == ST_IDLE) && start_i && !flush_i;
  assign stall_o = accept || (state_q == ST_CALC);

  assign sgn1_in = is_signed_rs1(op_in) & rs1_i[XLEN-1];
  assign sgn2_in = is_signed_rs2(op_in) & rs2_i[XLEN-1];

  muldiv_signfix #(.WA(XLEN), .WB(XLEN)) u_opfix (
    .a_i     (rs1_i),
    .neg_a_i (sgn1_in),
    .b_i     (rs2_i),
    .neg_b_i (sgn2_in),
    .a_c_o   (mag1),
    .b_c_o   (mag2)
  );

  // Divide-by-zero and signed overflow finish straight from IDLE with fixed results.
  assign div0    = (rs2_i == '0);
  assign ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1_i == INT_MIN) && (rs2_i == '1);
  assign special = is_div(op_in) && (div0 || ovf);
  always_comb begin
    spec_val = '0;
    if (div0) spec_val = is_rem(op_in) ? rs1_i : '1;
    else      spec_val = is_rem(op_in) ? '0 : rs1_i;
  end

  // One shift-add / restoring shift-subtract step on the accumulator.
  assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
  assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh  = acc_q[AW-1:XLEN-1];
  assign q_bit   = (rem_sh >= {1'b0, mc_q});
  assign rem_new = q_bit ? (rem_sh[XLEN-1:0] - mc_q) : rem_sh[XLEN-1:0];
  assign div_nx  = {rem_new, acc_q[XLEN-2:0], q_bit};
  assign acc_nx  = is_div(op_q) ? div_nx : mul_nx;

  assign div_sel = is_rem(op_q) ? acc_nx[AW-1:XLEN] : acc_nx[XLEN-1:0];

  muldiv_signfix #(.WA(AW), .WB(XLEN)) u_resfix (
    .a_i     (acc_nx),
    .neg_a_i (s1_q ^ s2_q),
    .b_i     (div_sel),
    .neg_b_i (is_rem(op_q) ? s1_q : (s1_q ^ s2_q)),
    .a_c_o   (fix_a),
    .b_c_o   (fix_b)
  );

  always_comb begin
    calc_res = fix_b;
    case (op_q)
      OP_MUL:                       calc_res = fix_a[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = fix_a[AW-1:XLEN];
      default:                      calc_res = fix_b;
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_d     = rd_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          tag_d = rd_i;
          s1_d  = sgn1_in;
          s2_d  = sgn2_in;
          mc_d  = is_div(op_in) ? mag2 : mag1;
          acc_d = {{XLEN{1'b0}}, (is_div(op_in) ? mag1 : mag2)};
          if (special) begin
            state_d  = ST_DONE;
            result_d = spec_val;
            rd_d     = rd_i;
            done_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CNT_W'(XLEN);
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_nx;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = ST_DONE;
            result_d = calc_res;
            rd_d     = tag_q;
            done_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      tag_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      mc_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule
